// File: rtl/apb_pkg.sv
// Shared definitions for the APB request-side arbiters.
//   arb_state_t : arbiter FSM encoding (ARB, ISSUE, WAIT, RESP)
//   APB_AW      : default address width
//   APB_DW      : default data width
package apb_pkg;

    localparam int unsigned APB_AW = 32;
    localparam int unsigned APB_DW = 32;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches the request vector starting at last_i+1 (mod N_REQ) and returns the
// first requester found.
//   req_i  : request vector
//   last_i : index of the most recently served requester
//   any_o  : at least one request is present
//   win_o  : one-hot winner (all zero when any_o is low)
//   idx_o  : encoded winner index (zero when any_o is low)
module rr_pick #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic             any_o,
    output logic [N_REQ-1:0] win_o,
    output logic [IW-1:0]    idx_o
);

    logic        found;
    int unsigned cand;

    // Walk the ring once, starting just after the last winner.
    always_comb begin
        win_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(last_i) + k) % N_REQ;
            if (!found && req_i[IW'(cand)]) begin
                found             = 1'b1;
                win_o[IW'(cand)]  = 1'b1;
                idx_o             = IW'(cand);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one apb_master request port among N_REQ
// requesters. One transaction in flight at a time: the winner's payload is
// latched, a single-cycle m_req is issued, and the master's response is
// routed back to the winner with a one-cycle s_done pulse.
//   pclk, preset_n          : clock, async active-low reset
//   s_valid/s_addr/s_wr/s_wdata : requester-side request (flattened per requester)
//   s_gnt, s_done           : one-hot grant and completion pulse
//   s_rdata, s_error        : response of the completed transfer
//   m_req/m_addr/m_wr/m_wdata : request to apb_master
//   m_rdata/m_done/m_error  : response from apb_master
//   busy                    : high whenever the FSM is outside ARB
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned AW    = APB_AW,
    parameter int unsigned DW    = APB_DW
) (
    input  logic                pclk,
    input  logic                preset_n,
    input  logic [N_REQ-1:0]    s_valid,
    input  logic [N_REQ*AW-1:0] s_addr,
    input  logic [N_REQ-1:0]    s_wr,
    input  logic [N_REQ*DW-1:0] s_wdata,
    output logic [N_REQ-1:0]    s_gnt,
    output logic [N_REQ-1:0]    s_done,
    output logic [DW-1:0]       s_rdata,
    output logic                s_error,
    output logic                m_req,
    output logic [AW-1:0]       m_addr,
    output logic                m_wr,
    output logic [DW-1:0]       m_wdata,
    input  logic [DW-1:0]       m_rdata,
    input  logic                m_done,
    input  logic                m_error,
    output logic                busy
);

    localparam int unsigned IW = $clog2(N_REQ);

    arb_state_t       state_q,   state_d;
    logic [IW-1:0]    last_q,    last_d;
    logic [IW-1:0]    win_idx_q, win_idx_d;
    logic [N_REQ-1:0] s_gnt_q,   s_gnt_d;
    logic [N_REQ-1:0] s_done_q,  s_done_d;
    logic [DW-1:0]    s_rdata_q, s_rdata_d;
    logic             s_error_q, s_error_d;
    logic             m_req_q,   m_req_d;
    logic [AW-1:0]    m_addr_q,  m_addr_d;
    logic             m_wr_q,    m_wr_d;
    logic [DW-1:0]    m_wdata_q, m_wdata_d;

    logic             pick_any;
    logic [N_REQ-1:0] pick_win;
    logic [IW-1:0]    pick_idx;

    // Round-robin winner among the current requests.
    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req_i  (s_valid),
        .last_i (last_q),
        .any_o  (pick_any),
        .win_o  (pick_win),
        .idx_o  (pick_idx)
    );

    // State and output registers.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= ARB;
            last_q    <= IW'(N_REQ - 1);
            win_idx_q <= '0;
            s_gnt_q   <= '0;
            s_done_q  <= '0;
            s_rdata_q <= '0;
            s_error_q <= 1'b0;
            m_req_q   <= 1'b0;
            m_addr_q  <= '0;
            m_wr_q    <= 1'b0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            win_idx_q <= win_idx_d;
            s_gnt_q   <= s_gnt_d;
            s_done_q  <= s_done_d;
            s_rdata_q <= s_rdata_d;
            s_error_q <= s_error_d;
            m_req_q   <= m_req_d;
            m_addr_q  <= m_addr_d;
            m_wr_q    <= m_wr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        win_idx_d = win_idx_q;
        s_gnt_d   = s_gnt_q;
        s_done_d  = '0;
        s_rdata_d = s_rdata_q;
        s_error_d = s_error_q;
        m_req_d   = 1'b0;
        m_addr_d  = m_addr_q;
        m_wr_d    = m_wr_q;
        m_wdata_d = m_wdata_q;

        unique case (state_q)
            ARB: begin
                // Payload only changes here, so the master always sees it stable.
                if (pick_any) begin
                    win_idx_d = pick_idx;
                    s_gnt_d   = pick_win;
                    m_req_d   = 1'b1;
                    m_addr_d  = s_addr[32'(pick_idx) * AW +: AW];
                    m_wr_d    = s_wr[pick_idx];
                    m_wdata_d = s_wdata[32'(pick_idx) * DW +: DW];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // m_done is only honoured here; stray pulses elsewhere are dropped.
                if (m_done) begin
                    s_rdata_d = m_rdata;
                    s_error_d = m_error;
                    s_done_d  = s_gnt_q;
                    state_d   = RESP;
                end
            end
            RESP: begin
                last_d  = win_idx_q;
                s_gnt_d = '0;
                state_d = ARB;
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    assign s_gnt   = s_gnt_q;
    assign s_done  = s_done_q;
    assign s_rdata = s_rdata_q;
    assign s_error = s_error_q;
    assign m_req   = m_req_q;
    assign m_addr  = m_addr_q;
    assign m_wr    = m_wr_q;
    assign m_wdata = m_wdata_q;

    // Straight decode of the state register.
    assign busy = (state_q != ARB);

endmodule
